// File: rtl/vc_credit_tracker_pkg.sv
// Shared definitions for the VC credit tracker: per-VC state encoding and
// default sizing of the downstream VC buffers.
package vc_credit_tracker_pkg;

  localparam int DEF_N_OF_VN       = 3;
  localparam int DEF_N_OF_VC       = 2;
  localparam int DEF_BUFFER_DEPTH  = 4;
  localparam int DEF_N_BITS_CREDIT = 3;

  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_ACTIVE = 2'd1,
    VC_DRAIN  = 2'd2
  } vc_state_e;

  // Flat VC index is v = vn*N_OF_VC + vc_index.
  function automatic int tot_vc(input int n_of_vn, input int n_of_vc);
    return n_of_vn * n_of_vc;
  endfunction

endpackage

// File: rtl/vc_credit_fsm.sv
// One downstream VC: IDLE/ACTIVE/DRAIN state plus credit counter.
// The err port exists only when VC_CREDIT_ERROR_CHECK_EN is defined.
module vc_credit_fsm
  import vc_credit_tracker_pkg::*;
#(
  parameter int BUFFER_DEPTH  = DEF_BUFFER_DEPTH,
  parameter int N_BITS_CREDIT = DEF_N_BITS_CREDIT
) (
  input  logic clk,
  input  logic rst,
  input  logic alloc,
  input  logic send,
  input  logic tail,
  input  logic credit_ret,
  output logic busy,
  output logic avail
`ifdef VC_CREDIT_ERROR_CHECK_EN
  ,
  output logic err
`endif
);

  localparam logic [N_BITS_CREDIT-1:0] FULL = N_BITS_CREDIT'(BUFFER_DEPTH);
  localparam logic [N_BITS_CREDIT-1:0] ONE  = N_BITS_CREDIT'(1);

  vc_state_e                state_reg, state_next;
  logic [N_BITS_CREDIT-1:0] credit_reg, credit_next;
  logic                     has_credit, full, send_ok;

  assign has_credit = (credit_reg != '0);
  assign full       = (credit_reg == FULL);
  assign send_ok    = send && (state_reg == VC_ACTIVE) && has_credit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= VC_IDLE;
      credit_reg <= FULL;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    unique case (state_reg)
      VC_IDLE:   if (alloc) state_next = VC_ACTIVE;
      VC_ACTIVE: if (send_ok && tail) state_next = VC_DRAIN;
      // Leaving on the registered full count keeps busy up one extra cycle,
      // and any alloc arriving in that cycle is dropped.
      VC_DRAIN:  if (full) state_next = VC_IDLE;
      default:   state_next = VC_IDLE;
    endcase
    if (send_ok && !credit_ret)
      credit_next = credit_reg - ONE;
    else if (!send_ok && credit_ret && !full)
      credit_next = credit_reg + ONE;
  end

  assign busy  = (state_reg != VC_IDLE);
  assign avail = (state_reg == VC_ACTIVE) && has_credit;

`ifdef VC_CREDIT_ERROR_CHECK_EN
  assign err = (alloc && state_reg != VC_IDLE) ||
               (send && !send_ok) ||
               (credit_ret && !send_ok && full);
`endif

endmodule

// File: rtl/vc_credit_tracker.sv
// Per-VC lifecycle and credit tracking for the NIC-to-NoC VC allocator.
// Define VC_CREDIT_ERROR_CHECK_EN to enable the sticky error_o flag.
module vc_credit_tracker
  import vc_credit_tracker_pkg::*;
#(
  parameter int N_OF_VN       = DEF_N_OF_VN,
  parameter int N_OF_VC       = DEF_N_OF_VC,
  parameter int N_TOT_OF_VC   = tot_vc(N_OF_VN, N_OF_VC),
  parameter int BUFFER_DEPTH  = DEF_BUFFER_DEPTH,
  parameter int N_BITS_CREDIT = DEF_N_BITS_CREDIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_TOT_OF_VC-1:0] alloc_vc_i,
  input  logic                   flit_send_i,
  input  logic [N_TOT_OF_VC-1:0] flit_vc_i,
  input  logic                   flit_tail_i,
  input  logic [N_TOT_OF_VC-1:0] credit_i,
  output logic [N_TOT_OF_VC-1:0] vc_busy_o,
  output logic [N_TOT_OF_VC-1:0] credit_avail_o,
  output logic                   error_o
);

  // A multi-hot VC select makes the whole send void, on every VC.
  logic multi_hot;
  assign multi_hot = !$onehot0(flit_vc_i);

`ifdef VC_CREDIT_ERROR_CHECK_EN
  logic [N_TOT_OF_VC-1:0] vc_err;
`endif

  generate
    for (genvar gi = 0; gi < N_TOT_OF_VC; gi++) begin : g_vc
      vc_credit_fsm #(
        .BUFFER_DEPTH  (BUFFER_DEPTH),
        .N_BITS_CREDIT (N_BITS_CREDIT)
      ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .alloc      (alloc_vc_i[gi]),
        .send       (flit_send_i && flit_vc_i[gi] && !multi_hot),
        .tail       (flit_tail_i),
        .credit_ret (credit_i[gi]),
        .busy       (vc_busy_o[gi]),
        .avail      (credit_avail_o[gi])
`ifdef VC_CREDIT_ERROR_CHECK_EN
        ,
        .err        (vc_err[gi])
`endif
      );
    end
  endgenerate

`ifdef VC_CREDIT_ERROR_CHECK_EN
  logic error_reg;

  always_ff @(posedge clk) begin
    if (rst)
      error_reg <= 1'b0;
    else if ((|vc_err) || (flit_send_i && multi_hot))
      error_reg <= 1'b1;
  end

  assign error_o = error_reg;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_credit_tracker.sv
// Directed bench for vc_credit_tracker; expected error_o follows
// whether VC_CREDIT_ERROR_CHECK_EN is defined for the build.
module tb_vc_credit_tracker;

`ifdef VC_CREDIT_ERROR_CHECK_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] alloc_vc, flit_vc, credit, vc_busy, credit_avail;
  logic       flit_send, flit_tail, error;

  int tests = 0;
  int fails = 0;

  vc_credit_tracker dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_vc_i     (alloc_vc),
    .flit_send_i    (flit_send),
    .flit_vc_i      (flit_vc),
    .flit_tail_i    (flit_tail),
    .credit_i       (credit),
    .vc_busy_o      (vc_busy),
    .credit_avail_o (credit_avail),
    .error_o        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    alloc_vc  = '0;
    flit_send = 1'b0;
    flit_vc   = '0;
    flit_tail = 1'b0;
    credit    = '0;
  endtask

  // One clock edge with the current inputs, then inputs back to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [5:0] vc, input logic t);
    flit_send = 1'b1;
    flit_vc   = vc;
    flit_tail = t;
    step();
  endtask

  initial begin
    idle_in();
    do_reset();
    chk("rst_busy",  8'(vc_busy), 8'h00);
    chk("rst_avail", 8'(credit_avail), 8'h00);
    chk("rst_err",   8'(error), 8'h00);

    // Full packet life on VC2
    alloc_vc = 6'b000100; step();
    chk("vc2_busy_after_alloc",  8'(vc_busy), 8'h04);
    chk("vc2_avail_after_alloc", 8'(credit_avail), 8'h04);
    for (int i = 0; i < 3; i++) begin
      send(6'b000100, 1'b0);
      chk($sformatf("vc2_avail_send%0d", i + 1), 8'(credit_avail), 8'h04);
    end
    send(6'b000100, 1'b1);
    chk("vc2_avail_after_tail", 8'(credit_avail), 8'h00);
    chk("vc2_busy_drain",       8'(vc_busy), 8'h04);
    for (int i = 0; i < 4; i++) begin
      credit = 6'b000100; step();
    end
    chk("vc2_busy_at_full",    8'(vc_busy), 8'h04);
    step();
    chk("vc2_busy_cleared",    8'(vc_busy), 8'h00);
    chk("vc2_no_err",          8'(error), 8'h00);

    // VC0: simultaneous send and credit at credit 1, then send at credit 0
    alloc_vc = 6'b000001; step();
    for (int i = 0; i < 3; i++) send(6'b000001, 1'b0);
    chk("vc0_avail_credit1", 8'(credit_avail), 8'h01);
    flit_send = 1'b1; flit_vc = 6'b000001; credit = 6'b000001; step();
    chk("vc0_avail_send_and_credit", 8'(credit_avail), 8'h01);
    chk("vc0_err_clean", 8'(error), 8'h00);
    send(6'b000001, 1'b0);
    chk("vc0_avail_credit0", 8'(credit_avail), 8'h00);
    send(6'b000001, 1'b0);
    chk("vc0_err_send_no_credit", 8'(error), 8'(E));
    chk("vc0_busy_still_active",  8'(vc_busy), 8'h01);
    credit = 6'b000001; step();
    chk("vc0_avail_after_return", 8'(credit_avail), 8'h01);
    do_reset();
    chk("reset_clears_err",  8'(error), 8'h00);
    chk("reset_clears_busy", 8'(vc_busy), 8'h00);

    // VC1: send while IDLE is ignored
    send(6'b000010, 1'b0);
    chk("vc1_err_idle_send", 8'(error), 8'(E));
    chk("vc1_busy_idle",     8'(vc_busy), 8'h00);
    alloc_vc = 6'b000010; step();
    for (int i = 0; i < 3; i++) send(6'b000010, 1'b0);
    chk("vc1_avail_after3", 8'(credit_avail), 8'h02);
    send(6'b000010, 1'b0);
    chk("vc1_avail_after4", 8'(credit_avail), 8'h00);
    do_reset();

    // VC3: credit return at full saturates, error is sticky
    credit = 6'b001000; step();
    chk("vc3_err_saturate", 8'(error), 8'(E));
    step();
    step();
    chk("vc3_err_sticky", 8'(error), 8'(E));
    alloc_vc = 6'b001000; step();
    for (int i = 0; i < 3; i++) send(6'b001000, 1'b0);
    chk("vc3_avail_after3", 8'(credit_avail), 8'h08);
    send(6'b001000, 1'b0);
    chk("vc3_avail_after4", 8'(credit_avail), 8'h00);
    do_reset();
    chk("vc3_reset_err", 8'(error), 8'h00);

    // VC5 single-flit packet alongside alloc on VC4
    alloc_vc = 6'b100000; step();
    flit_send = 1'b1; flit_vc = 6'b100000; flit_tail = 1'b1; alloc_vc = 6'b010000; step();
    chk("vc45_busy",  8'(vc_busy), 8'h30);
    chk("vc45_avail", 8'(credit_avail), 8'h10);
    credit = 6'b100000; step();
    chk("vc5_busy_at_full", 8'(vc_busy), 8'h30);
    step();
    chk("vc5_idle_busy",  8'(vc_busy), 8'h10);
    chk("vc4_avail_only", 8'(credit_avail), 8'h10);
    chk("vc45_no_err",    8'(error), 8'h00);

    // Multi-hot send with tail must not touch VC4
    send(6'b110000, 1'b1);
    chk("multihot_busy",  8'(vc_busy), 8'h10);
    chk("multihot_avail", 8'(credit_avail), 8'h10);
    chk("multihot_err",   8'(error), 8'(E));

    // Alloc in the DRAIN-to-IDLE cycle is dropped
    alloc_vc = 6'b100000; step();
    send(6'b100000, 1'b1);
    credit = 6'b100000; step();
    chk("vc5_drain_full_busy", 8'(vc_busy), 8'h30);
    alloc_vc = 6'b100000; step();
    chk("vc5_alloc_dropped", 8'(vc_busy), 8'h10);
    step();
    chk("vc5_stays_idle",    8'(vc_busy), 8'h10);

    do_reset();
    chk("final_rst_busy", 8'(vc_busy), 8'h00);
    chk("final_rst_err",  8'(error), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vc_credit_tracker.md
Name: vc_credit_tracker

Overview:
- Upstream companion of the NIC-to-NoC virtual channel allocator.
- Tracks each downstream router VC through its whole life:
  - allocation grant;
  - flit transmission, spending credits;
  - tail departure;
  - credit return.
- Drives the per-VC busy vector that feeds the allocator's fifo pointer state input. Also drives per-VC credit availability for the switch/link stage.

Parameters:
- N_OF_VN, 3, number of virtual networks
- N_OF_VC, 2, VCs per virtual network
- N_TOT_OF_VC, 6, N_OF_VN*N_OF_VC; VC v = vn*N_OF_VC + vc_index
- BUFFER_DEPTH, 4, flit slots per downstream VC buffer (initial credit count)
- N_BITS_CREDIT, 3, counter width; holds 0..BUFFER_DEPTH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_vc_i  in  N_TOT_OF_VC  VCs granted this cycle (OR of the allocator's one-hot grants)
- flit_send_i  in  1  flit leaves the NIC this cycle
- flit_vc_i  in  N_TOT_OF_VC  one-hot VC of the sent flit
- flit_tail_i  in  1  sent flit is a tail (head+tail single-flit packets included)
- credit_i  in  N_TOT_OF_VC  one credit returned per set bit
- vc_busy_o  out  N_TOT_OF_VC  high = VC not free for allocation
- credit_avail_o  out  N_TOT_OF_VC  high = VC ACTIVE with credit > 0
- error_o  out  1  sticky protocol-error flag (see Optional Feature)

Behaviour:
- Each VC has a 3-state FSM and a credit counter.
  - IDLE: free. Credit == BUFFER_DEPTH.
  - ACTIVE: allocated, tail not yet sent.
  - DRAIN: tail sent, waiting for all credits to return.
- Reset (rst high at a clk edge):
  - all VCs go to IDLE with credit = BUFFER_DEPTH;
  - vc_busy_o = 0, credit_avail_o = 0, error_o = 0.
  - A reset in the middle of a packet abandons all state; no credits are retained.
- Outputs are decoded from registered state only, with no input-to-output combinational path.
  - vc_busy_o[v] = (state != IDLE).
  - credit_avail_o[v] = ACTIVE & credit != 0.
- Transitions for VC v:
  - IDLE & alloc_vc_i[v]: go to ACTIVE; vc_busy_o rises the next cycle.
  - alloc_vc_i[v] in ACTIVE/DRAIN: ignored (protocol error).
  - Valid send: flit_send_i & flit_vc_i[v] & ACTIVE & credit != 0. Credit decrements.
    - If flit_tail_i is also set: go to DRAIN.
  - Send in IDLE/DRAIN or with credit 0: ignored, counter unchanged (protocol error).
  - credit_i[v]: credit increments. A return at BUFFER_DEPTH saturates (protocol error).
  - Valid send and credit_i on the same VC in the same cycle: credit unchanged.
  - DRAIN: go to IDLE in the cycle after the counter reaches BUFFER_DEPTH. Concretely, when the registered count equals BUFFER_DEPTH, move to IDLE on the next edge.
  - ACTIVE: never returns to IDLE directly.
- flit_vc_i with more than one bit set: the whole send is ignored (protocol error).
- Latency:
  - a credit returned at cycle t makes credit_avail_o usable at t+1;
  - busy clears at least 2 cycles after the final credit return, which gives the allocator a conservative view.
- Reallocation: a VC cannot be reallocated while its vc_busy_o is high. An alloc and the DRAIN-to-IDLE transition in the same cycle leave the VC in IDLE; the alloc is dropped.

Optional Feature:
- Macro: VC_CREDIT_ERROR_CHECK_EN.
- Defined: error_o is set on any protocol error listed above and stays set until rst.
- Undefined: error_o is tied 0. The ignore/saturate behaviour is unchanged; only the flag logic is removed.

Decomposition:
- Shared package holds:
  - VC state encoding constants (VC_IDLE = 2'd0, VC_ACTIVE = 2'd1, VC_DRAIN = 2'd2);
  - default BUFFER_DEPTH;
  - N_TOT_OF_VC derivation.
- One natural sub-module, vc_credit_fsm: a single VC's FSM plus counter plus local error pulse. It is instantiated N_TOT_OF_VC times via generate.
- The top level handles:
  - one-hot check on flit_vc_i;
  - fan-out of inputs to the VC instances;
  - OR of the error pulses into error_o.

Test Plan:
- Reset → vc_busy_o = 6'b000000, credit_avail_o = 0, error_o = 0; every counter = 4.
- Alloc VC2 at t0 → busy[2] = 1 at t1. Send 4 flits with the tail on the 4th → credit_avail_o[2] = 0 after the 4th send, state DRAIN. Return 4 credits → busy[2] = 0 two cycles after the 4th credit.
- VC0 ACTIVE with credit 1: send and credit_i[0] in the same cycle → credit stays 1, credit_avail_o[0] stays 1.
- Send on VC1 while IDLE, or with credit 0 → counter unchanged, error_o = 1 (macro on), error_o = 0 (macro off).
- credit_i[3] while VC3 IDLE at 4 → counter stays 4, error_o sticky 1. Assert rst → error_o = 0.
- Single-flit head+tail on VC5 plus alloc on VC4 → VC5 goes to DRAIN and then IDLE after 1 credit. VC4 is independent: busy[4] = 1, no cross-talk.
